mmss_timer: RTL and testbench

- Parametrised MM:SS BCD timer, successor to the fixed up-only seconds/minutes counter.
- Counts one step per qualified `pulse` tick, either up (stopwatch) or down (countdown).
- Supports preset load, synchronous clear, run/pause, and wrap or saturate at the limits.
- Emits status strobes for the display/control layer: rollover, done and at-zero.

---
 rtl/mmss_timer.sv | 144 ++++++++++++++
 tb/tb_mmss_timer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mmss_timer.sv
// MM:SS BCD up/down timer with preset load, clear, wrap/saturate limits
// and registered rollover/done strobes.
module mmss_timer #(
    parameter int MIN_TENS_MAX = 5,
    parameter int WRAP         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse,
    input  logic       run,
    input  logic       dir,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_min_tens,
    input  logic [3:0] load_min_units,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_units,
    output logic [3:0] seconds_units,
    output logic [3:0] seconds_tens,
    output logic [3:0] minutes_units,
    output logic [3:0] minutes_tens,
    output logic       rollover,
    output logic       done,
    output logic       at_zero
);

    localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

    logic [3:0] su, st, mu, mt;
    logic [3:0] su_n, st_n, mu_n, mt_n;
    logic       roll_q, done_q, roll_n, done_n;
    logic       is_max, is_zero, is_one;

    function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign is_max  = (mt == MT_MAX) && (mu == 4'd9) && (st == 4'd5) && (su == 4'd9);
    assign is_zero = (mt == '0) && (mu == '0) && (st == '0) && (su == '0);
    assign is_one  = (mt == '0) && (mu == '0) && (st == '0) && (su == 4'd1);

    always_comb begin
        su_n   = su;
        st_n   = st;
        mu_n   = mu;
        mt_n   = mt;
        roll_n = 1'b0;
        done_n = 1'b0;
        if (clear) begin
            su_n = '0;
            st_n = '0;
            mu_n = '0;
            mt_n = '0;
        end else if (load) begin
            su_n = clamp(load_sec_units, 4'd9);
            st_n = clamp(load_sec_tens, 4'd5);
            mu_n = clamp(load_min_units, 4'd9);
            mt_n = clamp(load_min_tens, MT_MAX);
        end else if (pulse && run) begin
            if (!dir) begin
                // Limit checked first so the carry chain never pushes minutes-tens past its maximum.
                if (is_max) begin
                    if (WRAP != 0) begin
                        su_n   = '0;
                        st_n   = '0;
                        mu_n   = '0;
                        mt_n   = '0;
                        roll_n = 1'b1;
                    end
                end else if (su != 4'd9) begin
                    su_n = su + 4'd1;
                end else begin
                    su_n = '0;
                    if (st != 4'd5) begin
                        st_n = st + 4'd1;
                    end else begin
                        st_n = '0;
                        if (mu != 4'd9) begin
                            mu_n = mu + 4'd1;
                        end else begin
                            mu_n = '0;
                            mt_n = mt + 4'd1;
                        end
                    end
                end
            end else begin
                if (is_zero) begin
                    if (WRAP != 0) begin
                        su_n   = 4'd9;
                        st_n   = 4'd5;
                        mu_n   = 4'd9;
                        mt_n   = MT_MAX;
                        roll_n = 1'b1;
                    end
                end else begin
                    done_n = is_one;
                    if (su != '0) begin
                        su_n = su - 4'd1;
                    end else begin
                        su_n = 4'd9;
                        if (st != '0) begin
                            st_n = st - 4'd1;
                        end else begin
                            st_n = 4'd5;
                            if (mu != '0) begin
                                mu_n = mu - 4'd1;
                            end else begin
                                mu_n = 4'd9;
                                mt_n = mt - 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            su     <= '0;
            st     <= '0;
            mu     <= '0;
            mt     <= '0;
            roll_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            su     <= su_n;
            st     <= st_n;
            mu     <= mu_n;
            mt     <= mt_n;
            roll_q <= roll_n;
            done_q <= done_n;
        end
    end

    assign seconds_units = su;
    assign seconds_tens  = st;
    assign minutes_units = mu;
    assign minutes_tens  = mt;
    assign rollover      = roll_q;
    assign done          = done_q;
    assign at_zero       = is_zero;

endmodule

// File: tb/tb_mmss_timer.sv
// Directed bench for mmss_timer: one wrapping and one saturating instance
// driven by identical stimulus, checked against hand-computed MM:SS values.
module tb_mmss_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse = 1'b0, run = 1'b0, dir = 1'b0, clear = 1'b0, load = 1'b0;
    logic [3:0] lmt = '0, lmu = '0, lst = '0, lsu = '0;

    logic [3:0] su_w, st_w, mu_w, mt_w, su_s, st_s, mu_s, mt_s;
    logic       roll_w, done_w, zero_w, roll_s, done_s, zero_s;
    logic [15:0] t_w, t_s;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    assign t_w = {mt_w, mu_w, st_w, su_w};
    assign t_s = {mt_s, mu_s, st_s, su_s};

    mmss_timer #(.MIN_TENS_MAX(5), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .pulse(pulse), .run(run), .dir(dir),
        .clear(clear), .load(load),
        .load_min_tens(lmt), .load_min_units(lmu),
        .load_sec_tens(lst), .load_sec_units(lsu),
        .seconds_units(su_w), .seconds_tens(st_w),
        .minutes_units(mu_w), .minutes_tens(mt_w),
        .rollover(roll_w), .done(done_w), .at_zero(zero_w)
    );

    mmss_timer #(.MIN_TENS_MAX(5), .WRAP(0)) dut_s (
        .clk(clk), .rst(rst), .pulse(pulse), .run(run), .dir(dir),
        .clear(clear), .load(load),
        .load_min_tens(lmt), .load_min_units(lmu),
        .load_sec_tens(lst), .load_sec_units(lsu),
        .seconds_units(su_s), .seconds_tens(st_s),
        .minutes_units(mu_s), .minutes_tens(mt_s),
        .rollover(roll_s), .done(done_s), .at_zero(zero_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_pulse;
        pulse = 1'b1;
        cyc();
        pulse = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        {lmt, lmu, lst, lsu} = v;
        cyc();
        load = 1'b0;
    endtask

    // Strobes packed as {roll_w, done_w, roll_s, done_s}.
    function automatic logic [3:0] strobes;
        return {roll_w, done_w, roll_s, done_s};
    endfunction

    initial begin
        logic [3:0] sticky;

        // Asynchronous reset, checked before any clock edge
        #2 rst = 1'b0;
        #1;
        chk("reset_time_w", t_w, 16'h0000);
        chk("reset_time_s", t_s, 16'h0000);
        chk("reset_zero", {zero_w, zero_s}, 2'b11);
        chk("reset_strobes", strobes(), 4'b0000);
        cyc();
        @(negedge clk) rst = 1'b1;
        cyc();

        // Up count, 61 pulses -> 01:01
        run = 1'b1;
        dir = 1'b0;
        sticky = '0;
        for (int i = 0; i < 61; i++) begin
            do_pulse();
            if (i == 0) chk("first_pulse_zero", {zero_w, zero_s}, 2'b00);
            sticky = sticky | strobes();
        end
        chk("up61_w", t_w, 16'h0101);
        chk("up61_s", t_s, 16'h0101);
        chk("up61_strobes", sticky, 4'b0000);

        // Wrap/saturate at the top
        do_load(16'h5958);
        chk("load5958", {t_w, t_s}, {16'h5958, 16'h5958});
        chk("load_strobes", strobes(), 4'b0000);
        do_pulse();
        chk("up_5959", {t_w, t_s}, {16'h5959, 16'h5959});
        chk("up_5959_strobes", strobes(), 4'b0000);
        do_pulse();
        chk("up_wrap_w", t_w, 16'h0000);
        chk("up_sat_s", t_s, 16'h5959);
        chk("up_wrap_strobes", strobes(), 4'b1000);
        cyc();
        chk("roll_one_cycle", strobes(), 4'b0000);

        // Down count through zero
        do_load(16'h0002);
        dir = 1'b1;
        do_pulse();
        chk("dn_0001", {t_w, t_s}, {16'h0001, 16'h0001});
        chk("dn_0001_strobes", strobes(), 4'b0000);
        do_pulse();
        chk("dn_0000", {t_w, t_s}, {16'h0000, 16'h0000});
        chk("dn_done", strobes(), 4'b0101);
        chk("dn_zero", {zero_w, zero_s}, 2'b11);
        do_pulse();
        chk("dn_wrap_w", t_w, 16'h5959);
        chk("dn_hold_s", t_s, 16'h0000);
        chk("dn_wrap_strobes", strobes(), 4'b1000);
        cyc();
        chk("dn_strobes_clear", strobes(), 4'b0000);

        // Clamping and clear priority
        clear = 1'b1;
        pulse = 1'b1;
        do_load(16'hFFFF);
        clear = 1'b0;
        chk("clear_wins", {t_w, t_s}, {16'h0000, 16'h0000});
        chk("clear_strobes", strobes(), 4'b0000);
        do_load(16'hFFFF);
        chk("clamp_FFFF", {t_w, t_s}, {16'h5959, 16'h5959});
        do_load(16'h3A72);
        chk("clamp_mixed", t_w, 16'h3952);
        do_load(16'h7B6B);
        chk("clamp_mt", t_s, 16'h5959);
        chk("clamp_strobes", strobes(), 4'b0000);

        // Pause, then direction change on the step edge
        do_load(16'h1000);
        run = 1'b0;
        dir = 1'b0;
        for (int i = 0; i < 5; i++) do_pulse();
        chk("paused", {t_w, t_s}, {16'h1000, 16'h1000});
        run = 1'b1;
        dir = 1'b1;
        do_pulse();
        chk("borrow_chain", {t_w, t_s}, {16'h0959, 16'h0959});
        dir = 1'b0;
        do_pulse();
        chk("carry_chain", {t_w, t_s}, {16'h1000, 16'h1000});

        // Asynchronous reset mid-count
        do_load(16'h3742);
        chk("pre_reset", t_w, 16'h3742);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_time", {t_w, t_s}, {16'h0000, 16'h0000});
        chk("async_rst_zero", {zero_w, zero_s}, 2'b11);
        pulse = 1'b1;
        cyc();
        chk("pulse_in_reset", t_w, 16'h0000);
        pulse = 1'b0;
        @(negedge clk) rst = 1'b1;
        do_pulse();
        chk("resume", {t_w, t_s}, {16'h0001, 16'h0001});
        chk("resume_strobes", strobes(), 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
